// File: rtl/uart_rx_sipo_if.sv
// Receive-side bundle between the serial line and the SIPO capture core.
// The slave modport is the receiver core; the master side drives the line and consumes frames.
interface uart_rx_sipo_if;
    logic        data_tx;
    logic        active_flag;
    logic        recieved_flag;
    logic [10:0] data_parll;

    modport master (
        output data_tx,
        input  active_flag,
        input  recieved_flag,
        input  data_parll
    );

    modport slave (
        input  data_tx,
        output active_flag,
        output recieved_flag,
        output data_parll
    );
endinterface

// File: rtl/uart_rx_sipo.sv
// UART receive SIPO: 16x oversampled start detection and capture of one 11-bit frame.
// Optional macro SIPO_START_GLITCH_REJECT_EN aborts frames whose mid-start sample reads high.
module uart_rx_sipo (
    input  logic           baud_clk,
    input  logic           rst_n,
    uart_rx_sipo_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, START, DATA} state_t;

    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [3:0]  bit_q, bit_d;
    logic [10:0] shift_q, shift_d;
    logic        sync1_q, sync_q;
    logic        active_q, active_d;
    logic        recv_q, recv_d;
    logic [10:0] parll_q, parll_d;
    logic [10:0] sampled;

    // New bit enters at the top so the first received bit lands in bit 0 after 11 shifts.
    assign sampled = {sync_q, shift_q[10:1]};

    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        active_d = active_q;
        recv_d   = 1'b0;
        parll_d  = parll_q;

        case (state_q)
            IDLE: begin
                tick_d = 4'd0;
                bit_d  = 4'd0;
                if (!sync_q) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (tick_q == 4'd7) begin
                    tick_d = 4'd0;
`ifdef SIPO_START_GLITCH_REJECT_EN
                    if (sync_q) begin
                        state_d  = IDLE;
                        active_d = 1'b0;
                    end else begin
                        shift_d = sampled;
                        bit_d   = 4'd1;
                        state_d = DATA;
                    end
`else
                    shift_d = sampled;
                    bit_d   = 4'd1;
                    state_d = DATA;
`endif
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            DATA: begin
                tick_d = tick_q + 4'd1;
                if (tick_q == 4'd15) begin
                    shift_d = sampled;
                    if (bit_q == 4'd10) begin
                        // Stop bit: publish the frame on the same edge that samples it.
                        bit_d    = 4'd0;
                        state_d  = IDLE;
                        active_d = 1'b0;
                        recv_d   = 1'b1;
                        parll_d  = sampled;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge baud_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tick_q   <= 4'd0;
            bit_q    <= 4'd0;
            shift_q  <= 11'd0;
            sync1_q  <= 1'b1;
            sync_q   <= 1'b1;
            active_q <= 1'b0;
            recv_q   <= 1'b0;
            parll_q  <= 11'd0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            sync1_q  <= bus.data_tx;
            sync_q   <= sync1_q;
            active_q <= active_d;
            recv_q   <= recv_d;
            parll_q  <= parll_d;
        end
    end

    assign bus.active_flag   = active_q;
    assign bus.recieved_flag = recv_q;
    assign bus.data_parll    = parll_q;
endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: table of frames plus glitch, reset and stuck-low sequences.
`timescale 1ns/1ps
module tb_uart_rx_sipo;
    logic baud_clk = 1'b0;
    logic rst_n    = 1'b1;

    uart_rx_sipo_if bus ();

    uart_rx_sipo dut (
        .baud_clk (baud_clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    always #3255.208 baud_clk = ~baud_clk;

    typedef struct {
        logic [7:0]  data;
        logic        parity;
        int          gap;
        logic [10:0] expected;
    } vec_t;

    vec_t        vecs [6];
    logic [10:0] exp_q [$];
    int          errors = 0;
    int          checks = 0;
    int          frames_seen = 0;
    int          cyc = 0;
    int          run_len = 0;
    int          last_run = 0;
    int          stuck_pulses = 0;
    int          last_pulse_cyc = 0;
    logic        stuck_mode = 1'b0;
    logic        prev_recv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.data_tx = b;
        repeat (16) @(negedge baud_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input int gap);
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(d[k]);
        send_bit(p);
        send_bit(1'b1);
        bus.data_tx = 1'b1;
        repeat (gap) @(negedge baud_clk);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(negedge baud_clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each received pulse and tracks active_flag run length.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge baud_clk);
            if (bus.recieved_flag) begin
                check("pulse_width", {31'd0, prev_recv}, 0);
                check("active_at_done", {31'd0, bus.active_flag}, 0);
                if (stuck_mode) begin
                    check("stuck_data", {21'd0, bus.data_parll}, 0);
                    if (stuck_pulses > 0) check("stuck_period", cyc - last_pulse_cyc, 169);
                    stuck_pulses++;
                    last_pulse_cyc = cyc;
                end else if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_frame: got data_parll=%0h expected no frame", bus.data_parll);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", {21'd0, bus.data_parll}, {21'd0, e});
                    frames_seen++;
                end
            end
            if (bus.active_flag) run_len++;
            else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
            prev_recv = bus.recieved_flag;
            cyc++;
        end
    end

    initial begin
        vecs[0] = '{data: 8'h55, parity: 1'b1, gap: 20, expected: 11'b11010101010};
        vecs[1] = '{data: 8'h55, parity: 1'b0, gap: 0,  expected: 11'b10010101010};
        vecs[2] = '{data: 8'hA3, parity: 1'b0, gap: 20, expected: 11'b10101000110};
        vecs[3] = '{data: 8'h00, parity: 1'b0, gap: 0,  expected: 11'b10000000000};
        vecs[4] = '{data: 8'hFF, parity: 1'b1, gap: 20, expected: 11'b11111111110};
        vecs[5] = '{data: 8'h81, parity: 1'b1, gap: 30, expected: 11'b11100000010};

        bus.data_tx = 1'b1;
        #10 rst_n = 1'b0;
        #100;
        check("rst_active", {31'd0, bus.active_flag}, 0);
        check("rst_recv", {31'd0, bus.recieved_flag}, 0);
        check("rst_parll", {21'd0, bus.data_parll}, 0);
        @(negedge baud_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge baud_clk);
        check("idle_active", {31'd0, bus.active_flag}, 0);

        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].expected);
            send_frame(vecs[i].data, vecs[i].parity, vecs[i].gap);
            if (i == 0) check("nominal_active_len", last_run, 168);
        end
        wait_drain();
        check("frames_seen", frames_seen, 6);

        // Short low glitch on an idle line.
        bus.data_tx = 1'b0;
        repeat (3) @(negedge baud_clk);
        check("glitch_active_start", {31'd0, bus.active_flag}, 1);
        bus.data_tx = 1'b1;
`ifdef SIPO_START_GLITCH_REJECT_EN
        repeat (20) @(negedge baud_clk);
        check("glitch_abort_active", {31'd0, bus.active_flag}, 0);
        repeat (200) @(negedge baud_clk);
`else
        exp_q.push_back(11'h7FF);
        wait_drain();
`endif
        repeat (10) @(negedge baud_clk);

        // Reset after start + 5 data bits: frame dropped, outputs cleared at once.
        send_bit(1'b0);
        for (int k = 0; k < 5; k++) send_bit(k[0]);
        #100 rst_n = 1'b0;
        #1;
        check("midrst_active", {31'd0, bus.active_flag}, 0);
        check("midrst_parll", {21'd0, bus.data_parll}, 0);
        bus.data_tx = 1'b1;
        #100 rst_n = 1'b1;
        repeat (20) @(negedge baud_clk);
        exp_q.push_back(11'b10101000110);
        send_frame(8'hA3, 1'b0, 20);
        wait_drain();

        // Stuck-low line: all-zero frames back to back.
        stuck_mode   = 1'b1;
        stuck_pulses = 0;
        bus.data_tx  = 1'b0;
        repeat (528) @(negedge baud_clk);
        check("stuck_pulses", stuck_pulses, 3);
        #100 rst_n = 1'b0;
        bus.data_tx = 1'b1;
        #100 rst_n = 1'b1;
        stuck_mode = 1'b0;
        repeat (200) @(negedge baud_clk);
        check("final_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
